// File: rtl/wb_machine_timer.sv
// wb_machine_timer: Wishbone B4 classic slave holding the RISC-V machine timer.
// mtime counts prescaled clk_i cycles; timer_interrupt is the registered level
// (mtime >= mtimecmp). Every bus request terminates after exactly one cycle.
module wb_machine_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        timer_interrupt
);

  // Prescale counter needs at least one bit even when PRESCALE is 1.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          en_q, en_d;
  logic [PW-1:0] psc_q, psc_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q, dat_d;
  logic          irq_q, irq_d;

  logic [2:0]    idx;
  logic          addr_ok;
  logic          req;
  logic          wr;
  logic          tick;
  logic [31:0]   read_val;

  // Only adr_i[4:2] selects a register; the remaining address bits are ignored.
  logic unused_adr;
  assign unused_adr = &{1'b0, adr_i[31:5], adr_i[1:0]};

  // Replace the bytes of old_word whose lane enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

  assign idx     = adr_i[4:2];
  assign addr_ok = (idx <= 3'd4);
  // A held strobe is not a new request while its termination is on the bus.
  assign req     = stb_i & cyc_i & ~ack_q & ~err_q;
  assign wr      = req & addr_ok & we_i;
  assign tick    = en_q & (psc_q == PS_LAST);

  // Read mux over the register map.
  always_comb begin
    read_val = 32'd0;
    case (idx)
      3'd0:    read_val = mtime_q[31:0];
      3'd1:    read_val = mtime_q[63:32];
      3'd2:    read_val = mtimecmp_q[31:0];
      3'd3:    read_val = mtimecmp_q[63:32];
      3'd4:    read_val = {31'd0, en_q};
      default: read_val = 32'd0;
    endcase
  end

  // Next-state: bus termination, register writes, prescaled counting, compare.
  always_comb begin
    ack_d      = req & addr_ok;
    err_d      = req & ~addr_ok;
    dat_d      = (req & addr_ok & ~we_i) ? read_val : 32'd0;

    psc_d      = psc_q;
    if (en_q) psc_d = tick ? '0 : psc_q + 1'b1;

    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;

    // A write to either mtime word overrides that edge's increment.
    if (wr) begin
      case (idx)
        3'd0:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], dat_i, sel_i)};
        3'd1:    mtime_d = {merge_bytes(mtime_q[63:32], dat_i, sel_i), mtime_q[31:0]};
        3'd2:    mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], dat_i, sel_i)};
        3'd3:    mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], dat_i, sel_i), mtimecmp_q[31:0]};
        3'd4:    if (sel_i[0]) en_d = dat_i[0];
        default: ;
      endcase
    end

    // Compare uses the values currently held, so the level lags by one edge.
    irq_d = (mtime_q >= mtimecmp_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b1;
      psc_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      psc_q      <= psc_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end

  assign dat_o           = dat_q;
  assign ack_o           = ack_q;
  assign err_o           = err_q;
  assign rty_o           = 1'b0;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_wb_machine_timer.sv
// tb_wb_machine_timer: directed and randomized Wishbone traffic against a
// behavioural timer model; every clock edge the bus outputs and the
// interrupt level are compared with the model's prediction.
module tb_wb_machine_timer;

  localparam int unsigned PRESCALE = 4;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;
  logic        timer_interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  int          m_enabled_cycles;
  logic        m_term;
  logic        m_ack;
  logic        m_err;
  logic [31:0] m_dat;
  logic        m_irq;

  wb_machine_timer #(.PRESCALE(PRESCALE)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .adr_i(adr_i),
    .dat_i(dat_i),
    .dat_o(dat_o),
    .sel_i(sel_i),
    .we_i(we_i),
    .stb_i(stb_i),
    .cyc_i(cyc_i),
    .ack_o(ack_o),
    .err_o(err_o),
    .rty_o(rty_o),
    .timer_interrupt(timer_interrupt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mtime          = 64'd0;
    m_cmp            = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en             = 1'b1;
    m_enabled_cycles = 0;
    m_term           = 1'b0;
    m_ack            = 1'b0;
    m_err            = 1'b0;
    m_dat            = 32'd0;
    m_irq            = 1'b0;
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:       return m_mtime[31:0];
      1:       return m_mtime[63:32];
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      4:       return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge: advance the model from the inputs present at the edge,
  // then compare the DUT outputs shortly after the edge.
  task automatic step();
    logic req, ok, inc, wr_time;
    int   idx;
    @(posedge clk_i);
    req     = stb_i && cyc_i && !m_term;
    idx     = int'(adr_i[4:2]);
    ok      = (idx <= 4);
    m_irq   = (m_mtime >= m_cmp);
    m_ack   = req && ok;
    m_err   = req && !ok;
    m_dat   = (req && ok && !we_i) ? model_read(idx) : 32'd0;
    inc     = 1'b0;
    if (m_en) begin
      m_enabled_cycles++;
      if (m_enabled_cycles % PRESCALE == 0) inc = 1'b1;
    end
    wr_time = req && ok && we_i && (idx <= 1);
    if (inc && !wr_time) m_mtime = m_mtime + 64'd1;
    if (req && ok && we_i) begin
      case (idx)
        0: m_mtime[31:0]  = lane_merge(m_mtime[31:0], dat_i, sel_i);
        1: m_mtime[63:32] = lane_merge(m_mtime[63:32], dat_i, sel_i);
        2: m_cmp[31:0]    = lane_merge(m_cmp[31:0], dat_i, sel_i);
        3: m_cmp[63:32]   = lane_merge(m_cmp[63:32], dat_i, sel_i);
        4: if (sel_i[0]) m_en = dat_i[0];
        default: ;
      endcase
    end
    m_term = m_ack || m_err;
    #1;
    check("ack_o", ack_o, m_ack);
    check("err_o", err_o, m_err);
    check("dat_o", dat_o, m_dat);
    check("rty_o", rty_o, 1'b0);
    check("irq", timer_interrupt, m_irq);
  endtask

  // Assert reset (outputs must drop at once), hold it, release on a falling edge.
  task automatic apply_reset();
    rst_ni = 1'b0;
    stb_i  = 1'b0;
    cyc_i  = 1'b0;
    we_i   = 1'b0;
    #1;
    check("rst_ack", ack_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", timer_interrupt, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    model_reset();
    rst_ni = 1'b1;
  endtask

  task automatic wb_access(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                           input logic [3:0] sel, output logic [31:0] rdata);
    adr_i = addr;
    we_i  = wr;
    dat_i = data;
    sel_i = sel;
    stb_i = 1'b1;
    cyc_i = 1'b1;
    step();
    rdata = dat_o;
    $display("[TB] %s adr=%08h dat_i=%08h sel=%b -> dat_o=%08h ack=%0b err=%0b",
             wr ? "WR" : "RD", addr, data, sel, dat_o, ack_o, err_o);
    stb_i = 1'b0;
    cyc_i = 1'b0;
    we_i  = 1'b0;
    step();
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] unused_rd;
    wb_access(addr, 1'b1, data, 4'hF, unused_rd);
  endtask

  task automatic rd32(input logic [31:0] addr, output logic [31:0] rdata);
    wb_access(addr, 1'b0, 32'd0, 4'hF, rdata);
  endtask

  initial begin
    logic [31:0] rd;
    int          err_pulses;
    bit          seen;

    rst_ni = 1'b1;
    adr_i  = 32'd0;
    dat_i  = 32'd0;
    sel_i  = 4'h0;
    we_i   = 1'b0;
    stb_i  = 1'b0;
    cyc_i  = 1'b0;
    model_reset();
    #3;
    apply_reset();

    // Reset values, first read on the first edge after release.
    rd32(32'h0, rd);  check("rst_mtime_lo", rd, 32'd0);
    rd32(32'h8, rd);  check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    rd32(32'h10, rd); check("rst_ctrl", rd, 32'd1);

    // 40 edges after release mtime is 10 with PRESCALE 4.
    repeat (34) step();
    rd32(32'h0, rd);  check("mtime_40clk", rd, 32'd10);

    // Disable counting and verify the value holds for 20 clocks.
    wr32(32'h10, 32'h0);
    rd32(32'h0, rd);  check("en0_hold_a", rd, 32'd10);
    repeat (20) step();
    rd32(32'h0, rd);  check("en0_hold_b", rd, 32'd10);
    wr32(32'h10, 32'h1);

    // Interrupt rises once mtime reaches the compare value.
    wr32(32'hC, 32'h0);
    wr32(32'h8, 32'd20);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (timer_interrupt) seen = 1;
    end
    check("irq_seen", seen, 1'b1);
    check("irq_mtime", m_mtime, 64'd20);
    wr32(32'h8, 32'd100);
    check("irq_cleared", timer_interrupt, 1'b0);

    // Carry from the low word into the high word.
    wr32(32'h4, 32'h0);
    wr32(32'h0, 32'hFFFF_FFFF);
    repeat (4) step();
    rd32(32'h4, rd);  check("carry_hi", rd, 32'd1);

    // Byte-lane write.
    wr32(32'h8, 32'hFFFF_FFFF);
    wb_access(32'h8, 1'b1, 32'h0000_AB00, 4'b0010, rd);
    rd32(32'h8, rd);  check("sel_merge", rd, 32'hFFFF_ABFF);

    // Unmapped index with the strobe held for three cycles.
    adr_i = 32'h14; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    err_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (err_o) err_pulses++;
      check("err_no_ack", ack_o, 1'b0);
      check("err_dat", dat_o, 32'd0);
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    step();
    check("err_pulses", err_pulses, 2);
    $display("[TB] ERR burst adr=00000014 pulses=%0d", err_pulses);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      int          idx;
      int          hold;
      logic [31:0] data;
      idx  = $urandom_range(0, 7);
      data = $urandom;
      if (idx == 2) data = m_mtime[31:0] + 32'($urandom_range(0, 40));
      if (idx == 3) data = m_mtime[63:32] + 32'($urandom_range(0, 1));
      if (idx == 4) data = {31'd0, 1'($urandom_range(0, 3) != 0)};
      adr_i = {27'($urandom), 3'(idx), 2'($urandom)};
      we_i  = 1'($urandom);
      dat_i = data;
      sel_i = 4'($urandom);
      stb_i = 1'b1;
      cyc_i = ($urandom_range(0, 7) != 0);
      hold  = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) step();
      $display("[TB] RND adr=%08h we=%0b dat_i=%08h sel=%b cyc=%0b hold=%0d mtime=%016h irq=%0b",
               adr_i, we_i, dat_i, sel_i, cyc_i, hold, m_mtime, m_irq);
      stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end

    // Reset while an acknowledge is on the bus.
    adr_i = 32'h0; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    step();
    check("pre_rst_ack", ack_o, 1'b1);
    apply_reset();
    rd32(32'h0, rd);  check("post_rst_mtime", rd, 32'd0);
    rd32(32'h10, rd); check("post_rst_ctrl", rd, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
